// File: rtl/rad_reader.sv
// rad_reader: host-side bus initiator for the Radboy cartridge mapper (latch write, reset write, 8 bit reads).
// Latency: START accepted at edge k; DONE/RESULT at edge k + 10*(T_SETUP+T_STROBE+T_HOLD).
// Backpressure: none queued; START is ignored while BUSY is high, so the host must wait for DONE.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   START, HV_ON        one-cycle request and the HV enable value written by the latch cycle
//   BUSY, DONE, RESULT  transaction status and the reassembled {nCHARGED, OVF, COUNT[5:0]} byte
//   nCS, nRD, nWR       cartridge chip select and strobes (active low)
//   A15, A14, A13       cartridge address bits
//   DATA_OUT, DATA_OE   DATA pad output value and output enable
//   DATA_IN             DATA pad input
module rad_reader #(
    parameter int T_SETUP  = 2,   // address/data/nCS setup cycles before the strobe (>= 1)
    parameter int T_STROBE = 4,   // cycles the strobe is held low (>= 1)
    parameter int T_HOLD   = 2    // address/data hold cycles after the strobe rises (>= 1)
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       HV_ON,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       nCS,
    output logic       nRD,
    output logic       nWR,
    output logic       A15,
    output logic       A14,
    output logic       A13,
    output logic       DATA_OUT,
    output logic       DATA_OE,
    input  logic       DATA_IN
);

    // The phase counter holds "cycles remaining minus one", so it never needs
    // to represent the largest parameter itself. A width of at least one bit
    // keeps the all-ones-parameter case legal.
    localparam int T_MAX = (T_SETUP > T_STROBE)
                         ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                         : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
    localparam int CW    = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);

    // Op indices: 0 = latch write, 1 = reset write, 2..9 = single-bit reads.
    localparam logic [3:0] OP_RESET_WR = 4'd1;
    localparam logic [3:0] OP_FIRST_RD = 4'd2;
    localparam logic [3:0] OP_LAST     = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_hv;
    logic [7:0]    r_shift;
    logic [7:0]    r_result;
    logic          r_done;

    state_t        w_state_n;
    logic [3:0]    w_op_n;
    logic [CW-1:0] w_cnt_n;
    logic          w_accept;
    logic          w_sample;
    logic          w_finish;
    logic          w_last;

    assign w_last = (r_cnt == '0);

    // ------------------------------------------------------------------
    // Next-state logic: SETUP -> STROBE -> HOLD per op, ten ops in a row.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_op_n    = r_op;
        w_cnt_n   = r_cnt;
        w_accept  = 1'b0;
        w_sample  = 1'b0;
        w_finish  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_accept  = 1'b1;
                    w_state_n = S_SETUP;
                    w_op_n    = 4'd0;
                    w_cnt_n   = LD_SETUP;
                end
            end

            S_SETUP: begin
                if (w_last) begin
                    w_state_n = S_STROBE;
                    w_cnt_n   = LD_STROBE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            S_STROBE: begin
                if (w_last) begin
                    // Sample on the final low cycle of nRD: the mapper only
                    // advances its bit index when nRD rises on the next edge.
                    w_sample  = (r_op >= OP_FIRST_RD);
                    w_state_n = S_HOLD;
                    w_cnt_n   = LD_HOLD;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            S_HOLD: begin
                if (w_last) begin
                    if (r_op == OP_LAST) begin
                        w_finish  = 1'b1;
                        w_state_n = S_IDLE;
                        w_op_n    = 4'd0;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = S_SETUP;
                        w_op_n    = r_op + 4'd1;
                        w_cnt_n   = LD_SETUP;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_op_n    = 4'd0;
                w_cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_op    <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_op    <= w_op_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hv     <= 1'b0;
            r_shift  <= 8'h00;
            r_result <= 8'h00;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hv <= HV_ON;
            end
            // Bits arrive LSB first, so shift in at the top: after eight
            // samples the first one has reached bit 0.
            if (w_sample) begin
                r_shift <= {DATA_IN, r_shift[7:1]};
            end
            // RESULT is only replaced at the end of a full transaction, so an
            // aborted run never exposes a partially assembled byte.
            if (w_finish) begin
                r_result <= r_shift;
            end
            r_done <= w_finish;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode. Everything is derived from the async-reset state
    // registers, so RESET releases strobes, nCS and DATA_OE together.
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_write_op;
    logic w_read_op;
    logic w_strobe;

    assign w_busy     = (r_state != S_IDLE);
    assign w_write_op = w_busy && (r_op < OP_FIRST_RD);
    assign w_read_op  = w_busy && (r_op >= OP_FIRST_RD);
    assign w_strobe   = (r_state == S_STROBE);

    assign BUSY     = w_busy;
    assign DONE     = r_done;
    assign RESULT   = r_result;

    assign nWR      = ~(w_strobe && w_write_op);
    assign nRD      = ~(w_strobe && w_read_op);
    assign nCS      = ~w_read_op;

    // Latch write = 000, reset write = 010, reads = 101, idle = 000.
    assign A15      = w_read_op;
    assign A14      = w_busy && (r_op == OP_RESET_WR);
    assign A13      = w_read_op;

    // The reset write drives 0; only the latch write carries HV_ON.
    assign DATA_OE  = w_write_op;
    assign DATA_OUT = w_busy && (r_op == 4'd0) && r_hv;

endmodule

// File: tb/tb_rad_reader.sv
module tb_rad_reader;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Instance a: default timing (2/4/2). Instance b: minimum timing (1/1/1).
    logic START_a, HV_a, BUSY_a, DONE_a, nCS_a, nRD_a, nWR_a, A15_a, A14_a, A13_a, DO_a, OE_a, DIN_a;
    logic START_b, HV_b, BUSY_b, DONE_b, nCS_b, nRD_b, nWR_b, A15_b, A14_b, A13_b, DO_b, OE_b, DIN_b;
    logic [7:0] RES_a, RES_b;

    rad_reader u_dut_a (
        .CLK(CLK), .RESET(RESET), .START(START_a), .HV_ON(HV_a),
        .BUSY(BUSY_a), .DONE(DONE_a), .RESULT(RES_a),
        .nCS(nCS_a), .nRD(nRD_a), .nWR(nWR_a),
        .A15(A15_a), .A14(A14_a), .A13(A13_a),
        .DATA_OUT(DO_a), .DATA_OE(OE_a), .DATA_IN(DIN_a)
    );

    rad_reader #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .START(START_b), .HV_ON(HV_b),
        .BUSY(BUSY_b), .DONE(DONE_b), .RESULT(RES_b),
        .nCS(nCS_b), .nRD(nRD_b), .nWR(nWR_b),
        .A15(A15_b), .A14(A14_b), .A13(A13_b),
        .DATA_OUT(DO_b), .DATA_OE(OE_b), .DATA_IN(DIN_b)
    );

    // ------------------------------------------------------------------
    // Mapper models: a snapshot byte read out one bit per nRD pulse.
    // The reset write clears the bit index, each nRD rise at the read
    // address advances it. The bit is only correct while nRD is low.
    // ------------------------------------------------------------------
    logic [7:0] snap_a = 8'h00, snap_b = 8'h00;
    logic [2:0] idx_a = 3'd0, idx_b = 3'd0;
    logic       p_nrd_a = 1'b1, p_nwr_a = 1'b1, p_nrd_b = 1'b1, p_nwr_b = 1'b1;
    logic [2:0] p_adr_a = 3'd0, p_adr_b = 3'd0;

    assign DIN_a = nRD_a ? ~snap_a[idx_a] : snap_a[idx_a];
    assign DIN_b = nRD_b ? ~snap_b[idx_b] : snap_b[idx_b];

    always @(negedge CLK) begin
        if (nRD_a && !p_nrd_a && p_adr_a == 3'b101) idx_a = idx_a + 3'd1;
        if (nWR_a && !p_nwr_a && p_adr_a == 3'b010) idx_a = 3'd0;
        if (nRD_b && !p_nrd_b && p_adr_b == 3'b101) idx_b = idx_b + 3'd1;
        if (nWR_b && !p_nwr_b && p_adr_b == 3'b010) idx_b = 3'd0;
        p_nrd_a = nRD_a; p_nwr_a = nWR_a; p_adr_a = {A15_a, A14_a, A13_a};
        p_nrd_b = nRD_b; p_nwr_b = nWR_b; p_adr_b = {A15_b, A14_b, A13_b};
    end

    // Bus invariants, every cycle, both instances.
    always @(negedge CLK) begin
        if (!RESET) begin
            checks = checks + 1;
            if ((!nRD_a && !nWR_a) || (!nWR_a && !(OE_a && nCS_a)) || (!nRD_a && !(!OE_a && !nCS_a))) begin
                failures = failures + 1;
                $display("FAIL invariant_a t=%0t nRD=%b nWR=%b nCS=%b OE=%b", $time, nRD_a, nWR_a, nCS_a, OE_a);
            end
            checks = checks + 1;
            if ((!nRD_b && !nWR_b) || (!nWR_b && !(OE_b && nCS_b)) || (!nRD_b && !(!OE_b && !nCS_b))) begin
                failures = failures + 1;
                $display("FAIL invariant_b t=%0t nRD=%b nWR=%b nCS=%b OE=%b", $time, nRD_b, nWR_b, nCS_b, OE_b);
            end
        end
    end

    // Bus vector: {BUSY, nCS, nRD, nWR, A15, A14, A13, DATA_OE, DATA_OUT}
    localparam logic [8:0] BUS_IDLE = 9'b0_111_000_00;

    logic [7:0] last_res [2];

    function automatic logic [8:0] bus_obs(input int w);
        if (w == 0) return {BUSY_a, nCS_a, nRD_a, nWR_a, A15_a, A14_a, A13_a, OE_a, DO_a};
        return {BUSY_b, nCS_b, nRD_b, nWR_b, A15_b, A14_b, A13_b, OE_b, DO_b};
    endfunction

    function automatic logic done_obs(input int w);
        return (w == 0) ? DONE_a : DONE_b;
    endfunction

    function automatic logic [7:0] res_obs(input int w);
        return (w == 0) ? RES_a : RES_b;
    endfunction

    // Expected bus at cycle c after the accepting edge, from op/phase arithmetic.
    function automatic logic [8:0] bus_exp(input int c, input int ts, input int tst, input int len, input logic hv);
        int op;
        int ph;
        logic stb;
        if (c >= 10 * len) return BUS_IDLE;
        op  = c / len;
        ph  = c % len;
        stb = (ph >= ts) && (ph < ts + tst);
        if (op == 0) return {1'b1, 1'b1, 1'b1, !stb, 1'b0, 1'b0, 1'b0, 1'b1, hv};
        if (op == 1) return {1'b1, 1'b1, 1'b1, !stb, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        return {1'b1, 1'b0, !stb, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic set_start(input int w, input logic s, input logic hv);
        if (w == 0) begin START_a = s; HV_a = hv; end
        else        begin START_b = s; HV_b = hv; end
    endtask

    // One full transaction with a cycle-by-cycle bus trace. pmask bit n puts
    // START high at edge k+n (must be ignored); chain raises START for the
    // edge right after DONE; started means the caller already raised START.
    task automatic run_txn(input int w, input logic hv, input logic [7:0] snap,
                           input logic [255:0] pmask, input bit started,
                           input bit chain, input logic chain_hv);
        int ts, tst, len;
        logic [8:0] exp_bus;
        ts  = (w == 0) ? 2 : 1;
        tst = (w == 0) ? 4 : 1;
        len = (w == 0) ? 8 : 3;
        if (w == 0) snap_a = snap; else snap_b = snap;
        if (!started) begin
            @(negedge CLK);
            set_start(w, 1'b1, hv);
        end
        @(posedge CLK);
        #1 set_start(w, 1'b0, 1'b0);
        for (int c = 0; c <= 10 * len; c++) begin
            @(negedge CLK);
            exp_bus = bus_exp(c, ts, tst, len, hv);
            checks = checks + 1;
            if (bus_obs(w) !== exp_bus) begin
                failures = failures + 1;
                $display("FAIL bus_trace dut=%0d cycle=%0d got=%b want=%b", w, c, bus_obs(w), exp_bus);
            end
            checks = checks + 1;
            if (done_obs(w) !== (c == 10 * len)) begin
                failures = failures + 1;
                $display("FAIL done_timing dut=%0d cycle=%0d got=%b", w, c, done_obs(w));
            end
            if (c < 10 * len) begin
                checks = checks + 1;
                if (res_obs(w) !== last_res[w]) begin
                    failures = failures + 1;
                    $display("FAIL result_hold dut=%0d cycle=%0d got=%h want=%h", w, c, res_obs(w), last_res[w]);
                end
                set_start(w, pmask[c + 1], hv);
            end else begin
                checks = checks + 1;
                if (res_obs(w) !== snap) begin
                    failures = failures + 1;
                    $display("FAIL result dut=%0d got=%h want=%h", w, res_obs(w), snap);
                end
                last_res[w] = snap;
                if (chain) set_start(w, 1'b1, chain_hv);
                else       set_start(w, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        set_start(0, 1'b0, 1'b0);
        set_start(1, 1'b0, 1'b0);
        last_res[0] = 8'h00;
        last_res[1] = 8'h00;
        repeat (3) @(negedge CLK);
        for (int w = 0; w < 2; w++) begin
            checks = checks + 1;
            if (bus_obs(w) !== BUS_IDLE) begin
                failures = failures + 1;
                $display("FAIL reset_bus dut=%0d got=%b want=%b", w, bus_obs(w), BUS_IDLE);
            end
            checks = checks + 1;
            if (done_obs(w) !== 1'b0 || res_obs(w) !== 8'h00) begin
                failures = failures + 1;
                $display("FAIL reset_status dut=%0d done=%b result=%h want 0/00", w, done_obs(w), res_obs(w));
            end
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic;
        run_txn(0, 1'b1, 8'hA5, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start;
        logic [255:0] pm;
        pm = '0;
        pm[10] = 1'b1;
        pm[79] = 1'b1;
        pm[80] = 1'b1;   // coincident with DONE: BUSY still high before that edge
        run_txn(0, 1'b0, 8'h5A, pm, 1'b0, 1'b1, 1'b1);
        run_txn(0, 1'b1, 8'hC3, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        run_txn(0, 1'b0, 8'h7F, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort;
        int dseen;
        @(negedge CLK);
        snap_a = 8'h3C;
        set_start(0, 1'b1, 1'b1);
        @(posedge CLK);
        #1 set_start(0, 1'b0, 1'b0);
        repeat (44) @(negedge CLK);   // cycle 43: op5 STROBE
        checks = checks + 1;
        if (nRD_a !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL abort_pre_strobe nRD got=%b want=0", nRD_a);
        end
        #1 RESET = 1'b1;
        #1;
        checks = checks + 1;
        if (bus_obs(0) !== BUS_IDLE || DONE_a !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL abort_immediate bus=%b done=%b want bus=%b done=0", bus_obs(0), DONE_a, BUS_IDLE);
        end
        #1 RESET = 1'b0;
        last_res[0] = 8'h00;
        last_res[1] = 8'h00;
        dseen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (DONE_a || BUSY_a) dseen = dseen + 1;
        end
        checks = checks + 1;
        if (dseen !== 0) begin
            failures = failures + 1;
            $display("FAIL abort_no_done activity_cycles got=%0d want=0", dseen);
        end
        checks = checks + 1;
        if (RES_a !== 8'h00) begin
            failures = failures + 1;
            $display("FAIL abort_result got=%h want=00", RES_a);
        end
        run_txn(0, 1'b1, 8'h96, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fast;
        run_txn(1, 1'b1, 8'hA5, '0, 1'b0, 1'b0, 1'b0);
        run_txn(1, 1'b0, 8'h7F, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            run_txn(i % 2, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_overflow();
        test_abort();
        test_fast();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
